// File: rtl/bcd_to_signed_bin.sv
// Sequential BCD-to-two's-complement converter (reverse double-dabble, one shift per cycle).
// Feeds signed operands from the digit-entry front end to the multiplier.
module bcd_to_signed_bin #(
    parameter int DIGITS = 3,
    parameter int MAG_W  = 10,
    parameter int OUT_W  = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  sign_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_W-1:0]      result,
    output logic                  err_digit,
    output logic                  err_range,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int WORK_W = 4*DIGITS + MAG_W;
    localparam int CNT_W  = $clog2(MAG_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] RANGE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(MAG_W - 1);
    localparam logic [MAG_W-1:0] POS_LIM    = MAG_W'(2**(OUT_W-1) - 1);
    localparam logic [MAG_W-1:0] NEG_LIM    = MAG_W'(2**(OUT_W-1));

    logic [1:0]        state;
    logic [WORK_W-1:0] work;
    logic [CNT_W-1:0]  cnt;
    logic              sign_q;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift right, then pull any digit >= 8 back by 3.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = w >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[MAG_W + 4*d +: 4] >= 4'd8)
                s[MAG_W + 4*d +: 4] = s[MAG_W + 4*d +: 4] - 4'd3;
        end
        return s;
    endfunction

    // Returns {overflow, value}; value is forced to zero on overflow.
    function automatic logic [OUT_W:0] range_check(input logic neg, input logic [MAG_W-1:0] mag);
        logic signed [MAG_W:0] val;
        logic                  over;
        over = neg ? (mag > NEG_LIM) : (mag > POS_LIM);
        val  = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        return over ? {1'b1, {OUT_W{1'b0}}} : {1'b0, val[OUT_W-1:0]};
    endfunction

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err_digit <= 1'b0;
            err_range <= 1'b0;
            work      <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= sign_in;
                        in_ready <= 1'b0;
                        if (has_bad_digit(bcd_in)) begin
                            err_digit <= 1'b1;
                            err_range <= 1'b0;
                            result    <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            err_digit <= 1'b0;
                            err_range <= 1'b0;
                            work      <= {bcd_in, {MAG_W{1'b0}}};
                            cnt       <= '0;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= dabble_step(work);
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_SHIFT) state <= RANGE;
                end
                // Low MAG_W bits of work now hold the unsigned magnitude.
                RANGE: begin
                    {err_range, result} <= range_check(sign_q, work[MAG_W-1:0]);
                    out_valid           <= 1'b1;
                    state               <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
